om_timing_ctrl: RTL and testbench

Converts the Oerder-Meyr CORDIC phase output into a smoothed fractional symbol timing offset, then drives symbol-rate sampling for the 4-samples-per-symbol receive stream. It sits directly downstream of the OM estimator. It consumes the 16-bit arctan result once per estimation block. It produces a per-sample symbol strobe, the selected sample index and the fractional interpolation value mu for the interpolator/decimator.

---
 rtl/om_pkg.sv | 27 ++
 rtl/om_tau_filter.sv | 52 +++++
 rtl/om_timing_ctrl.sv | 178 +++++++++++++++++
 tb/tb_om_timing_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/om_pkg.sv
// om_pkg: shared constants, state encoding and the phase normalisation helper
// for the Oerder-Meyr symbol timing controller.
package om_pkg;

    // 2^16 / (2*pi), rounded; with the fix16_13 phase this maps one full turn to 2^16.
    localparam int unsigned OM_INV_2PI    = 10430;
    localparam int unsigned OM_NORM_SHIFT = 13;
    localparam int unsigned OM_SPS_LOG2   = 2;

    // Controller states, kept as plain constants for compatibility with older blocks.
    typedef logic [1:0] om_state_t;
    localparam om_state_t IDLE  = 2'd0;
    localparam om_state_t ACQ   = 2'd1;
    localparam om_state_t TRACK = 2'd2;

    typedef enum logic {SHIFT_ACQ, SHIFT_TRK} om_shift_t;

    // Timing offset as a fraction of a symbol: -(eps * 10430) >>> 13, wrapped to 16 bits.
    function automatic logic [15:0] om_normalise(input logic signed [15:0] eps);
        logic signed [31:0] prod;
        logic signed [31:0] neg;
        prod = 32'(eps) * $signed(32'(OM_INV_2PI));
        neg  = -prod;
        return 16'(neg >>> OM_NORM_SHIFT);
    endfunction

endpackage

// File: rtl/om_tau_filter.sv
// om_tau_filter: first-order IIR on the circle of symbol phase. The error is
// taken as a signed 16-bit wrapped difference so the filter always moves the
// short way around, and the accumulator wraps modulo one symbol.
module om_tau_filter
    import om_pkg::*;
#(
    parameter int unsigned ACQ_SHIFT = 2,
    parameter int unsigned TRK_SHIFT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] t,
    input  logic        valid,
    input  logic        load,
    input  om_shift_t   shift_sel,
    output logic [15:0] tau
);

    localparam int unsigned AW       = 16 + TRK_SHIFT;
    localparam int unsigned ACQ_GAIN = TRK_SHIFT - ACQ_SHIFT;

    logic [AW-1:0]        acc_q;
    logic [AW-1:0]        acc_d;
    logic [AW-1:0]        step;
    logic signed [15:0]   d;
    logic signed [AW-1:0] d_ext;

    assign tau = acc_q[AW-1 -: 16];

    // Next accumulator: direct load on the first estimate, otherwise wrap-safe update.
    always_comb begin
        d     = t - tau;
        d_ext = AW'(d);
        step  = (shift_sel == SHIFT_ACQ) ? AW'(d_ext <<< ACQ_GAIN) : AW'(d_ext);
        acc_d = acc_q;
        if (load) begin
            acc_d = AW'(t) << TRK_SHIFT;
        end else if (valid) begin
            acc_d = acc_q + step;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/om_timing_ctrl.sv
// om_timing_ctrl: turns OM estimator phase into a smoothed symbol timing
// offset and drives per-window sample selection (sym_idx, mu, sym_strobe).
// Optional feature macro: OM_TIMING_SLIP_EN keeps strobe spacing within one
// sample of a symbol when the selected index wraps around the window.
module om_timing_ctrl
    import om_pkg::*;
#(
    parameter int unsigned SPS_LOG2  = OM_SPS_LOG2,
    parameter int unsigned ACQ_SHIFT = 2,
    parameter int unsigned TRK_SHIFT = 5,
    parameter int unsigned ACQ_N     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_valid,
    input  logic                 eps_valid,
    input  logic [15:0]          eps,
    output logic [15:0]          tau,
    output logic [SPS_LOG2-1:0]  sym_idx,
    output logic [15-SPS_LOG2:0] mu,
    output logic                 sym_strobe,
    output logic                 locked,
    output logic                 slip_fwd,
    output logic                 slip_bwd
);

    localparam int unsigned AC_W = $clog2(ACQ_N + 1);

    logic [15:0]          t_q;
    logic                 t_vld_q;
    om_state_t            state_q;
    om_state_t            state_d;
    logic [AC_W-1:0]      acq_cnt_q;
    logic [AC_W-1:0]      acq_cnt_d;
    logic [SPS_LOG2-1:0]  cnt_q;
    logic [SPS_LOG2-1:0]  sym_idx_q;
    logic [15-SPS_LOG2:0] mu_q;
    logic                 strobe_q;
    logic                 strobe_d;
    logic                 boundary;
    logic [SPS_LOG2-1:0]  new_idx;
    logic                 load;
    om_shift_t            shift_sel;

    // Stage 1: register the normalised timing offset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_q     <= '0;
            t_vld_q <= 1'b0;
        end else begin
            t_vld_q <= eps_valid;
            if (eps_valid) begin
                t_q <= om_normalise(eps);
            end
        end
    end

    assign load      = t_vld_q && (state_q == IDLE);
    assign shift_sel = (state_q == TRACK) ? SHIFT_TRK : SHIFT_ACQ;

    om_tau_filter #(
        .ACQ_SHIFT (ACQ_SHIFT),
        .TRK_SHIFT (TRK_SHIFT)
    ) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .t         (t_q),
        .valid     (t_vld_q),
        .load      (load),
        .shift_sel (shift_sel),
        .tau       (tau)
    );

    // Acquisition sequencing: state advances in step with the filter update.
    always_comb begin
        state_d   = state_q;
        acq_cnt_d = acq_cnt_q;
        if (t_vld_q) begin
            case (state_q)
                IDLE: begin
                    state_d   = ACQ;
                    acq_cnt_d = '0;
                end
                ACQ: begin
                    acq_cnt_d = acq_cnt_q + 1'b1;
                    if (acq_cnt_q == AC_W'(ACQ_N - 1)) begin
                        state_d = TRACK;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and acquisition counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acq_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acq_cnt_q <= acq_cnt_d;
        end
    end

    assign boundary = din_valid && (cnt_q == '0);
    assign new_idx  = tau[15 -: SPS_LOG2];

`ifdef OM_TIMING_SLIP_EN
    localparam logic [SPS_LOG2-1:0] IDX_MAX = '1;

    logic fwd_wrap;
    logic bwd_wrap;
    logic slip_fwd_q;
    logic slip_bwd_q;

    assign fwd_wrap = boundary && (sym_idx_q == IDX_MAX) && (new_idx == '0);
    assign bwd_wrap = boundary && (sym_idx_q == '0) && (new_idx == IDX_MAX);

    // Slip pulses are reported at the boundary that applied the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slip_fwd_q <= 1'b0;
            slip_bwd_q <= 1'b0;
        end else begin
            slip_fwd_q <= fwd_wrap && (state_q != IDLE);
            slip_bwd_q <= bwd_wrap && (state_q != IDLE);
        end
    end

    assign slip_fwd = slip_fwd_q;
    assign slip_bwd = slip_bwd_q;
`else
    assign slip_fwd = 1'b0;
    assign slip_bwd = 1'b0;
`endif

    // Strobe decision; at a boundary the freshly applied index is the one that counts.
    always_comb begin
        strobe_d = 1'b0;
        if (din_valid && (state_q != IDLE)) begin
            if (boundary) begin
`ifdef OM_TIMING_SLIP_EN
                // Forward wrap drops the cnt=0 strobe; backward wrap inserts one.
                strobe_d = ((new_idx == '0) && !fwd_wrap) || bwd_wrap;
`else
                strobe_d = (new_idx == '0);
`endif
            end else begin
                strobe_d = (cnt_q == sym_idx_q);
            end
        end
    end

    // Window counter, index application and registered strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            sym_idx_q <= '0;
            mu_q      <= '0;
            strobe_q  <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            if (din_valid) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (boundary) begin
                {sym_idx_q, mu_q} <= tau;
            end
        end
    end

    assign sym_idx    = sym_idx_q;
    assign mu         = mu_q;
    assign sym_strobe = strobe_q;
    assign locked     = (state_q == TRACK);

endmodule

// File: tb/tb_om_timing_ctrl.sv
// tb_om_timing_ctrl: scoreboard bench for om_timing_ctrl with default parameters.
module tb_om_timing_ctrl;

`ifdef OM_TIMING_SLIP_EN
    localparam bit SLIP = 1'b1;
`else
    localparam bit SLIP = 1'b0;
`endif
    localparam int ACC_MASK = (1 << 21) - 1;

    logic        clk;
    logic        rst_n;
    logic        din_valid;
    logic        eps_valid;
    logic [15:0] eps;
    logic [15:0] tau;
    logic [1:0]  sym_idx;
    logic [13:0] mu;
    logic        sym_strobe;
    logic        locked;
    logic        slip_fwd;
    logic        slip_bwd;

    om_timing_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .eps_valid  (eps_valid),
        .eps        (eps),
        .tau        (tau),
        .sym_idx    (sym_idx),
        .mu         (mu),
        .sym_strobe (sym_strobe),
        .locked     (locked),
        .slip_fwd   (slip_fwd),
        .slip_bwd   (slip_bwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] tau;
        logic [1:0]  idx;
        logic [13:0] mu;
        logic        stb;
        logic        lck;
        logic        sf;
        logic        sb;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_t, m_tv, m_acc, m_state, m_acq, m_cnt, m_idx, m_mu, m_stb, m_sf, m_sb;

    // Strobe-gap bookkeeping (din_valid held high while tracked)
    int cyc_no, last_stb, min_gap, max_gap, n_sf, n_sb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int norm(input int e);
        int p;
        p = e * 10430;
        return ((-p) >>> 13) & 16'hFFFF;
    endfunction

    task automatic model_step(input bit dv, input bit ev, input int e, input bit rn);
        int tau_old, st_old, d, ni;
        bit fw, bw;
        tau_old = m_acc >> 5;
        st_old  = m_state;
        if (!rn) begin
            m_t = 0; m_tv = 0; m_acc = 0; m_state = 0; m_acq = 0;
            m_cnt = 0; m_idx = 0; m_mu = 0; m_stb = 0; m_sf = 0; m_sb = 0;
        end else begin
            if (m_tv != 0) begin
                if (m_state == 0) begin
                    m_acc   = m_t << 5;
                    m_state = 1;
                    m_acq   = 0;
                end else begin
                    d = (m_t - tau_old) & 16'hFFFF;
                    if (d >= 32768) d -= 65536;
                    if (m_state == 1) begin
                        m_acc = (m_acc + d * 8) & ACC_MASK;
                        m_acq++;
                        if (m_acq == 8) m_state = 2;
                    end else begin
                        m_acc = (m_acc + d) & ACC_MASK;
                    end
                end
            end
            m_tv = ev;
            if (ev) m_t = norm(e);
            m_stb = 0; m_sf = 0; m_sb = 0;
            if (dv) begin
                if (m_cnt == 0) begin
                    ni = tau_old >> 14;
                    fw = (m_idx == 3) && (ni == 0);
                    bw = (m_idx == 0) && (ni == 3);
                    if (SLIP) begin
                        m_stb = ((ni == 0) && !fw) || bw;
                        m_sf  = fw;
                        m_sb  = bw;
                    end else begin
                        m_stb = (ni == 0);
                    end
                    m_idx = ni;
                    m_mu  = tau_old & 16383;
                end else begin
                    m_stb = (m_cnt == m_idx);
                end
                if (st_old == 0) begin
                    m_stb = 0; m_sf = 0; m_sb = 0;
                end
                m_cnt = (m_cnt + 1) % 4;
            end
        end
    endtask

    task automatic gap_reset();
        last_stb = -1; min_gap = 1000; max_gap = 0; n_sf = 0; n_sb = 0;
    endtask

    // One clock: drive, predict, then compare the popped prediction #1 after the edge.
    task automatic cycle(input bit dv, input bit ev, input int e, input bit rn);
        exp_t x;
        int g;
        rst_n     = rn;
        din_valid = dv;
        eps_valid = ev;
        eps       = 16'(e);
        model_step(dv, ev, e, rn);
        x.tau = 16'(m_acc >> 5);
        x.idx = 2'(m_idx);
        x.mu  = 14'(m_mu);
        x.stb = (m_stb != 0);
        x.lck = (m_state == 2);
        x.sf  = (m_sf != 0);
        x.sb  = (m_sb != 0);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        cyc_no++;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            x = exp_q.pop_front();
            check("tau", tau, x.tau);
            check("sym_idx", sym_idx, x.idx);
            check("mu", mu, x.mu);
            check("strobe", sym_strobe, x.stb);
            check("locked", locked, x.lck);
            check("slip_fwd", slip_fwd, x.sf);
            check("slip_bwd", slip_bwd, x.sb);
        end
        if (sym_strobe) begin
            if (last_stb >= 0) begin
                g = cyc_no - last_stb;
                if (g < min_gap) min_gap = g;
                if (g > max_gap) max_gap = g;
            end
            last_stb = cyc_no;
        end
        if (slip_fwd) n_sf++;
        if (slip_bwd) n_sb++;
    endtask

    task automatic est(input int e);
        cycle(1'b1, 1'b1, e, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 0, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 1'b0);
    endtask

    int n_stb;
    int prev_tau;
    bit wrapped;

    initial begin
        cyc_no = 0;
        gap_reset();
        do_reset();
        do_reset();
        check("rst_tau", tau, 0);
        check("rst_idx", sym_idx, 0);
        check("rst_strobe", sym_strobe, 0);
        check("rst_locked", locked, 0);

        // eps = 0: lock after the load plus eight filtered estimates
        repeat (8) est(0);
        check("lock_early", locked, 0);
        est(0);
        check("lock_set", locked, 1);
        n_stb = 0;
        repeat (16) begin
            cycle(1'b1, 1'b0, 0, 1'b1);
            if (sym_strobe) n_stb++;
        end
        check("stb_per_16", n_stb, 4);
        repeat (24) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 2000)) - 1000, 1'b1);

        // Direct load of T=16384
        do_reset();
        cycle(1'b1, 1'b1, -12869, 1'b1);
        check("ld_latency", tau, 0);
        cycle(1'b1, 1'b0, 0, 1'b1);
        check("ld_tau", tau, 16384);
        repeat (4) cycle(1'b1, 1'b0, 0, 1'b1);
        check("ld_idx", sym_idx, 1);
        check("ld_mu", mu, 0);

        // Direct load of T=-16384
        do_reset();
        cycle(1'b1, 1'b1, 12868, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b1);
        check("neg_tau", tau, 49152);
        repeat (4) cycle(1'b1, 1'b0, 0, 1'b1);
        check("neg_idx", sym_idx, 3);

        // Tracking gain: a 1024 step moves tau by 32
        do_reset();
        repeat (9) est(-12869);
        check("trk_locked", locked, 1);
        check("trk_base", tau, 16384);
        cycle(1'b1, 1'b1, -13673, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b1);
        check("trk_step", tau, 16416);

        // Forward wrap through 65535 -> 0
        do_reset();
        repeat (9) est(201);
        check("fwd_base", tau, 65280);
        gap_reset();
        wrapped  = 1'b0;
        prev_tau = tau;
        repeat (60) begin
            cycle(1'b1, 1'b1, -604, 1'b1);
            check("fwd_mono", ((tau - prev_tau) & 16'hFFFF) < 32768, 1);
            if (tau < prev_tau) wrapped = 1'b1;
            prev_tau = tau;
        end
        check("fwd_wrapped", wrapped, 1);
        check("fwd_gap", SLIP ? max_gap : min_gap, SLIP ? 5 : 1);
        check("fwd_nslip", n_sf, SLIP ? 1 : 0);

        // Backward wrap through 0 -> 65535
        do_reset();
        repeat (9) est(-201);
        gap_reset();
        repeat (60) cycle(1'b1, 1'b1, 604, 1'b1);
        check("bwd_gap", SLIP ? min_gap : max_gap, SLIP ? 3 : 7);
        check("bwd_nslip", n_sb, SLIP ? 1 : 0);

        // Reset in the middle of acquisition
        do_reset();
        est(12868);
        est(0);
        est(0);
        do_reset();
        check("mid_rst_tau", tau, 0);
        check("mid_rst_idx", sym_idx, 0);
        check("mid_rst_mu", mu, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_strobe", sym_strobe, 0);
        cycle(1'b1, 1'b1, -12869, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b1);
        check("mid_rst_reload", tau, 16384);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
